// File: rtl/pkg_mult.sv
// rtl/pkg_mult.sv - shared types and constants for the sequential Booth multiplier
package pkg_mult;

    localparam int DW    = 8;
    localparam int CNT_W = $clog2(DW + 1);

    typedef logic signed [2*DW-1:0] product_t;
    typedef logic signed [DW:0]     acc_t;
    typedef logic signed [DW-1:0]   operand_t;
    typedef logic [CNT_W-1:0]       count_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } booth_state_e;

endpackage

// File: rtl/booth_mult_seq_step.sv
// rtl/booth_mult_seq_step.sv - one radix-2 Booth add/sub plus arithmetic right shift
module booth_step
    import pkg_mult::*;
(
    input  acc_t     a,
    input  operand_t q,
    input  logic     q_1,
    input  operand_t m,
    output acc_t     a_next,
    output operand_t q_next,
    output logic     q_1_next
);

    acc_t m_ext;
    acc_t sum;

    // Add or subtract the sign-extended multiplicand, then shift {A,Q,Q_1} right by one.
    // A carries one guard bit so subtracting the most negative M cannot overflow.
    always_comb begin
        m_ext = {m[DW-1], m};
        sum   = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m_ext;
            2'b10:   sum = a - m_ext;
            default: sum = a;
        endcase
        a_next   = {sum[DW], sum[DW:1]};
        q_next   = {sum[0], q[DW-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with FSM and done pulse
module booth_mult_seq
    import pkg_mult::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DW-1:0]     i_multiplier,
    input  logic [DW-1:0]     i_multiplicand,
    output logic [2*DW-1:0]   o_product,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam count_t LAST_CNT = count_t'(DW - 1);

    booth_state_e state_q, state_d;
    acc_t         a_q;
    operand_t     q_q;
    logic         q_1_q;
    operand_t     m_q;
    count_t       count_q;
    product_t     product_q;

    acc_t         step_a;
    operand_t     step_q;
    logic         step_q_1;

    booth_step u_step (
        .a        (a_q),
        .q        (q_q),
        .q_1      (q_1_q),
        .m        (m_q),
        .a_next   (step_a),
        .q_next   (step_q),
        .q_1_next (step_q_1)
    );

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and status outputs decoded from the registered state.
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                o_busy  = 1'b1;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                o_busy = 1'b1;
                if (count_q == LAST_CNT) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, clear accumulator in LOAD, one Booth step per CALC cycle.
    // The product register is written on the final step so it is already valid while o_done is high.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_q       <= '0;
            q_q       <= '0;
            q_1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        m_q <= i_multiplicand;
                        q_q <= i_multiplier;
                    end
                end
                ST_LOAD: begin
                    a_q     <= '0;
                    q_1_q   <= 1'b0;
                    count_q <= '0;
                end
                ST_CALC: begin
                    a_q     <= step_a;
                    q_q     <= step_q;
                    q_1_q   <= step_q_1;
                    count_q <= count_q + count_t'(1);
                    if (count_q == LAST_CNT) product_q <= {step_a[DW-1:0], step_q};
                end
                default: ;
            endcase
        end
    end

    assign o_product = product_q;

endmodule
